dffram_arbiter: RTL

Two-requester round-robin arbiter that shares one DFFRAMD single-port word memory (4096 x 32, byte write mask, 1-cycle registered read) between an instruction-fetch port and a data port. It sits between the core's two memory interfaces and the memory macro. It converts byte addresses to word indices, range-checks them against the memory window, and returns a per-port response one cycle after grant. Out-of-window accesses return an error response without touching the memory.

---
 rtl/dffram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one single-port DFFRAM word memory between an
// ifetch port (0) and a data port (1); out-of-window accesses get an error response.

module dffram_arbiter_port #(
  parameter int unsigned TW       = 18,
  parameter logic [TW-1:0] BASE_TAG = '0,
  parameter int unsigned IDX      = 0
) (
  input  logic [TW-1:0] tag,
  input  logic          resp_vld,
  input  logic          resp_port,
  input  logic          resp_err,
  input  logic [31:0]   mem_do,
  output logic          hit,
  output logic          rvalid,
  output logic          err,
  output logic [31:0]   rdata
);
  assign hit    = (tag == BASE_TAG);
  assign rvalid = resp_vld && (resp_port == 1'(IDX));
  assign err    = rvalid && resp_err;
  // Read data is a shared bus; zero it when idle or for an errored access.
  assign rdata  = (resp_vld && !resp_err) ? mem_do : 32'h0;
endmodule

module dffram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [3:0]    be0_i,
  input  logic [31:0]   addr0_i,
  input  logic [31:0]   wdata0_i,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [3:0]    be1_i,
  input  logic [31:0]   addr1_i,
  input  logic [31:0]   wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [31:0]   rdata0_o,
  output logic [31:0]   rdata1_o,
  output logic          err0_o,
  output logic          err1_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_a_o,
  output logic [31:0]   mem_di_o,
  input  logic [31:0]   mem_do_i
);
  localparam int NP = 2;
  localparam int TW = 32 - (AW + 2);

  logic [NP-1:0]       req, we, gnt, hit, rvalid, err;
  logic [NP-1:0][3:0]  be;
  logic [NP-1:0][31:0] addr, wdata, rdata;
  logic                last, sel, resp_port, resp_err;
  logic [1:0]          vld_pipe;
  logic                unused_lo;

  assign req   = {req1_i, req0_i};
  assign we    = {we1_i, we0_i};
  assign be    = {be1_i, be0_i};
  assign addr  = {addr1_i, addr0_i};
  assign wdata = {wdata1_i, wdata0_i};
  assign unused_lo = ^{addr0_i[1:0], addr1_i[1:0]};

  // Tie goes to the port that did not win last; nothing is granted under reset.
  always_comb begin
    gnt    = '0;
    gnt[0] = !RST && req[0] && (!req[1] || last);
    gnt[1] = !RST && req[1] && (!req[0] || !last);
  end

  // With no grant sel is 0, so the memory bus idles on the port-0 inputs.
  assign sel = gnt[1];

  always_comb begin
    vld_pipe[0] = |gnt;
  end

  assign mem_en_o = vld_pipe[0] && hit[sel];
  assign mem_we_o = (mem_en_o && we[sel]) ? be[sel] : 4'b0000;
  assign mem_a_o  = addr[sel][AW+1:2];
  assign mem_di_o = wdata[sel];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last        <= 1'b1;
      vld_pipe[1] <= 1'b0;
      resp_port   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        last      <= sel;
        resp_port <= sel;
        resp_err  <= !hit[sel];
      end
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    dffram_arbiter_port #(
      .TW       (TW),
      .BASE_TAG (BASE_ADDR[31:AW+2]),
      .IDX      (p)
    ) u_port (
      .tag       (addr[p][31:AW+2]),
      .resp_vld  (vld_pipe[1]),
      .resp_port (resp_port),
      .resp_err  (resp_err),
      .mem_do    (mem_do_i),
      .hit       (hit[p]),
      .rvalid    (rvalid[p]),
      .err       (err[p]),
      .rdata     (rdata[p])
    );
  end

  assign gnt0_o    = gnt[0];
  assign gnt1_o    = gnt[1];
  assign rvalid0_o = rvalid[0];
  assign rvalid1_o = rvalid[1];
  assign err0_o    = err[0];
  assign err1_o    = err[1];
  assign rdata0_o  = rdata[0];
  assign rdata1_o  = rdata[1];
endmodule
